// File: rtl/text_pkg.sv
// Shared constants and types for the text display write path.
package text_pkg;

   localparam logic [7:0] CH_SPACE    = 8'h20;
   localparam logic [7:0] CH_BS       = 8'h08;
   localparam logic [7:0] CH_LF       = 8'h0A;
   localparam logic [7:0] CH_CR       = 8'h0D;
   localparam logic [7:0] CH_FF       = 8'h0C;
   localparam logic [7:0] CH_PRINT_LO = 8'h20;
   localparam logic [7:0] CH_PRINT_HI = 8'h7E;

   localparam int unsigned DEF_COLS = 16;
   localparam int unsigned DEF_ROWS = 2;
   localparam int unsigned CHAR_W   = 8;
   localparam int unsigned CHAR_H   = 16;

   typedef enum logic {
      ST_CLEAR,
      ST_IDLE
   } state_t;

   function automatic logic is_printable(input logic [7:0] c);
      return (c >= CH_PRINT_LO) && (c <= CH_PRINT_HI);
   endfunction

endpackage

// File: rtl/text_line_writer_if.sv
// Byte stream handshake into the text line writer.
interface text_line_writer_if;

   logic       in_valid;
   logic [7:0] in_char;
   logic       in_ready;

   modport master (output in_valid, output in_char, input  in_ready);
   modport slave  (input  in_valid, input  in_char, output in_ready);

endinterface

// File: rtl/text_ram.sv
// Character buffer: one synchronous write port, one synchronous read-before-write read port.
module text_ram #(
   parameter int unsigned DEPTH = 32,
   parameter int unsigned AW    = 5
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [7:0]    wdata,
   input  logic [AW-1:0] raddr,
   output logic [7:0]    rd_data
);

   logic [7:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      rd_data <= mem[raddr];
   end

endmodule

// File: rtl/text_line_writer.sv
// Accepts ASCII bytes, maintains the write cursor and control codes, and
// fills the ROWS x COLS character buffer read by the display side.
module text_line_writer
   import text_pkg::*;
#(
   parameter  int unsigned COLS = DEF_COLS,
   parameter  int unsigned ROWS = DEF_ROWS,
   localparam int unsigned RW   = (ROWS > 1) ? $clog2(ROWS) : 1,
   localparam int unsigned CW   = $clog2(COLS)
) (
   input  logic                clk,
   input  logic                rst,
   text_line_writer_if.slave   in_if,
   input  logic [RW-1:0]       rd_row,
   input  logic [CW-1:0]       rd_col,
   output logic [7:0]          rd_char,
   output logic [RW-1:0]       cursor_row,
   output logic [CW-1:0]       cursor_col,
   output logic                busy
);

   localparam int unsigned DEPTH     = ROWS * COLS;
   localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
   localparam logic [RW-1:0] LAST_ROW  = RW'(ROWS - 1);
   localparam logic [RW:0]   ROWS_LIM  = (RW + 1)'(ROWS);

   state_t          state;
   logic [AW-1:0]   clr_addr;
   logic            in_ready_q;
   logic            accept;
   logic            we;
   logic [AW-1:0]   waddr;
   logic [7:0]      wdata;
   logic [7:0]      ram_q;
   logic            rd_blank_q;

   // COLS is a power of two, so row*COLS + col is a plain concatenation.
   function automatic logic [AW-1:0] cell_addr(input logic [RW-1:0] r, input logic [CW-1:0] c);
      logic [RW+CW-1:0] full;
      full = {r, c};
      return full[AW-1:0];
   endfunction

   function automatic logic [RW-1:0] next_row(input logic [RW-1:0] r);
      return (r == LAST_ROW) ? '0 : r + 1'b1;
   endfunction

   assign in_if.in_ready = in_ready_q;
   assign accept         = in_if.in_valid & in_ready_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_CLEAR;
         clr_addr   <= '0;
         cursor_row <= '0;
         cursor_col <= '0;
         in_ready_q <= 1'b0;
         busy       <= 1'b1;
      end else begin
         case (state)
            ST_CLEAR: begin
               if (clr_addr == LAST_ADDR) begin
                  state      <= ST_IDLE;
                  in_ready_q <= 1'b1;
                  busy       <= 1'b0;
                  cursor_row <= '0;
                  cursor_col <= '0;
               end else begin
                  clr_addr <= clr_addr + 1'b1;
               end
            end
            ST_IDLE: begin
               if (accept) begin
                  if (is_printable(in_if.in_char)) begin
                     if (cursor_col == '1) begin
                        cursor_col <= '0;
                        cursor_row <= next_row(cursor_row);
                     end else begin
                        cursor_col <= cursor_col + 1'b1;
                     end
                  end else if (in_if.in_char == CH_BS) begin
                     if (cursor_col != '0) cursor_col <= cursor_col - 1'b1;
                  end else if (in_if.in_char == CH_CR) begin
                     cursor_col <= '0;
                  end else if (in_if.in_char == CH_LF) begin
                     cursor_row <= next_row(cursor_row);
                  end else if (in_if.in_char == CH_FF) begin
                     state      <= ST_CLEAR;
                     clr_addr   <= '0;
                     cursor_row <= '0;
                     cursor_col <= '0;
                     in_ready_q <= 1'b0;
                     busy       <= 1'b1;
                  end
               end
            end
            default: state <= ST_CLEAR;
         endcase
      end
   end

   // BS at column 0 blanks (row, 0) in place; otherwise it blanks the cell left of the cursor.
   always_comb begin
      we    = 1'b0;
      waddr = clr_addr;
      wdata = CH_SPACE;
      if (state == ST_CLEAR) begin
         we = 1'b1;
      end else if (accept) begin
         if (is_printable(in_if.in_char)) begin
            we    = 1'b1;
            waddr = cell_addr(cursor_row, cursor_col);
            wdata = in_if.in_char;
         end else if (in_if.in_char == CH_BS) begin
            we    = 1'b1;
            waddr = cell_addr(cursor_row, (cursor_col == '0) ? '0 : cursor_col - 1'b1);
         end
      end
   end

   text_ram #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk     (clk),
      .we      (we),
      .waddr   (waddr),
      .wdata   (wdata),
      .raddr   (cell_addr(rd_row, rd_col)),
      .rd_data (ram_q)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) rd_blank_q <= 1'b1;
      else     rd_blank_q <= ({1'b0, rd_row} >= ROWS_LIM);
   end

   assign rd_char = rd_blank_q ? CH_SPACE : ram_q;

endmodule

// File: tb/tb_text_line_writer.sv
// Directed bench for text_line_writer at the default 16 x 2 geometry.
module tb_text_line_writer;
   import text_pkg::*;

   localparam int unsigned COLS = 16;
   localparam int unsigned ROWS = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic [0:0] rd_row;
   logic [3:0] rd_col;
   logic [7:0] rd_char;
   logic [0:0] cursor_row;
   logic [3:0] cursor_col;
   logic       busy;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   text_line_writer_if bus ();

   text_line_writer #(
      .COLS (COLS),
      .ROWS (ROWS)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_if      (bus.slave),
      .rd_row     (rd_row),
      .rd_col     (rd_col),
      .rd_char    (rd_char),
      .cursor_row (cursor_row),
      .cursor_col (cursor_col),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] c);
      check($sformatf("ready before %02h", c), 32'(bus.in_ready), 1);
      bus.in_valid = 1'b1;
      bus.in_char  = c;
      tick();
      bus.in_valid = 1'b0;
   endtask

   task automatic check_cursor(input string tag, input int unsigned r, input int unsigned c);
      check({tag, " row"}, 32'(cursor_row), r);
      check({tag, " col"}, 32'(cursor_col), c);
   endtask

   task automatic read_cell(input int unsigned r, input int unsigned c, input logic [7:0] exp);
      rd_row = 1'(r);
      rd_col = 4'(c);
      tick();
      check($sformatf("cell(%0d,%0d)", r, c), 32'(rd_char), 32'(exp));
   endtask

   task automatic wait_clear(input string tag);
      int unsigned n;
      n = 0;
      while (busy && n < 200) begin
         tick();
         n++;
      end
      check({tag, " busy cycles"}, n, 32);
      check({tag, " in_ready"}, 32'(bus.in_ready), 1);
      check_cursor(tag, 0, 0);
   endtask

   initial begin
      rst          = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_char  = 8'h00;
      rd_row       = '0;
      rd_col       = '0;
      repeat (3) tick();

      check("rst in_ready", 32'(bus.in_ready), 0);
      check("rst busy", 32'(busy), 1);
      check_cursor("rst", 0, 0);
      check("rst rd_char", 32'(rd_char), 32'h20);

      rst = 1'b0;
      wait_clear("init");
      for (int r = 0; r < 2; r++)
         for (int c = 0; c < 16; c++)
            read_cell(r, c, 8'h20);

      // "HI" back to back
      send(8'h48);
      send(8'h49);
      check_cursor("HI", 0, 2);
      rd_row = 1'b0;
      rd_col = 4'd0;
      tick();
      check("HI c0", 32'(rd_char), 32'h48);
      rd_col = 4'd1;
      #2;
      check("HI latency hold", 32'(rd_char), 32'h48);
      tick();
      check("HI c1", 32'(rd_char), 32'h49);

      send(CH_FF);
      wait_clear("ff1");

      // 16 x 'A' then 16 x 'B'
      for (int i = 0; i < 16; i++) send(8'h41);
      check_cursor("after16", 1, 0);
      for (int i = 0; i < 16; i++) send(8'h42);
      check_cursor("after32", 0, 0);
      for (int c = 0; c < 16; c++) read_cell(0, c, 8'h41);
      for (int c = 0; c < 16; c++) read_cell(1, c, 8'h42);

      // FF on a full buffer
      send(CH_FF);
      check("ff2 in_ready fall", 32'(bus.in_ready), 0);
      check("ff2 busy rise", 32'(busy), 1);
      wait_clear("ff2");
      for (int r = 0; r < 2; r++)
         for (int c = 0; c < 16; c++)
            read_cell(r, c, 8'h20);

      // control codes
      send(8'h41);
      send(8'h42);
      send(CH_BS);
      check_cursor("BS", 0, 1);
      read_cell(0, 1, 8'h20);
      read_cell(0, 0, 8'h41);
      send(CH_CR);
      check_cursor("CR", 0, 0);
      send(CH_BS);
      check_cursor("BS col0", 0, 0);
      read_cell(0, 0, 8'h20);
      send(8'h58);
      check_cursor("X", 0, 1);
      send(CH_LF);
      check_cursor("LF1", 1, 1);
      send(CH_LF);
      check_cursor("LF2", 0, 1);
      send(8'h07);
      check_cursor("BEL", 0, 1);
      check("BEL busy", 32'(busy), 0);
      read_cell(0, 1, 8'h20);
      read_cell(0, 0, 8'h58);

      // reset at clear cycle 10
      send(CH_FF);
      repeat (10) tick();
      check("midclr busy", 32'(busy), 1);
      rst = 1'b1;
      repeat (3) tick();
      check("midclr rst busy", 32'(busy), 1);
      rst = 1'b0;
      wait_clear("midclr");
      read_cell(0, 0, 8'h20);
      read_cell(1, 15, 8'h20);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/text_line_writer.md
# text_line_writer

Write-side companion to the text display path. Accepts a stream of ASCII bytes over a valid/ready handshake and places them into an on-chip character buffer of ROWS × COLS cells. The block manages the cursor, control codes and screen clear. The display side reads the same buffer through a synchronous read port, one character code per pixel-derived (row, col) address.

## Interface
- COLS, default 16: characters per row; power of two, ≥ 2.
- ROWS, default 2: number of rows (message lines); ≥ 1.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  in_char is valid this cycle.
- in_char  in  8  ASCII byte.
- in_ready  out  1  block accepts in_char this cycle.
- rd_row  in  RW  display read row; RW = max(1, $clog2(ROWS)).
- rd_col  in  CW  display read column; CW = $clog2(COLS).
- rd_char  out  8  character at (rd_row, rd_col), registered.
- cursor_row  out  RW  current write row.
- cursor_col  out  CW  current write column.
- busy  out  1  clear sequence in progress.

## Operation
- FSM states: CLEAR and IDLE.
  - Reset forces CLEAR with clr_addr = 0.
  - CLEAR writes 0x20 to cell clr_addr each cycle, in row-major order (addr = row*COLS + col), with in_ready = 0 and busy = 1.
  - After the write to address ROWS*COLS-1, the FSM goes to IDLE, cursor = (0,0) and busy = 0.
- IDLE: in_ready = 1. A byte transfers on in_valid & in_ready and is processed in that same cycle.
  - 0x20–0x7E (printable): write the byte at the cursor, then advance the cursor.
    - If col < COLS-1: col+1.
    - Otherwise: col = 0 and row = (row+1) mod ROWS.
  - 0x08 (BS): if col > 0, col−1 and write 0x20 at the new column. If col = 0, the cursor is unchanged and 0x20 is written at (row, 0).
  - 0x0D (CR): col = 0; no write.
  - 0x0A (LF): row = (row+1) mod ROWS; col unchanged; no write.
  - 0x0C (FF): go to CLEAR. Cursor is forced to (0,0) at entry.
  - Any other byte is accepted and discarded; nothing changes.
- Reset asserted at any time, including mid-CLEAR, restarts CLEAR from address 0.
- Read port:
  - Always active, including during CLEAR. It returns the current RAM contents, so cells not yet cleared may hold stale data.
  - A read and a write to the same cell in the same cycle returns the old data (read-before-write).
- Out-of-range rd_row (≥ ROWS, only possible when ROWS is not a power of two) returns 0x20.

## Timing
- Reset values:
  - in_ready = 0, busy = 1
  - cursor_row = 0, cursor_col = 0
  - rd_char = 0x20
  - state = CLEAR, clr_addr = 0
- Clear duration: exactly ROWS*COLS cycles with busy = 1, counted from the first clk edge after rst deasserts or after FF acceptance. in_ready rises on the following cycle. Default: 32 cycles.
- Write latency:
  - The accepted character is written on the acceptance edge.
  - The cursor outputs update on the same edge.
  - Sustained throughput is one byte per cycle in IDLE.
- Read latency: 1 cycle. rd_char at edge n+1 reflects the (rd_row, rd_col) sampled at edge n.
- in_ready is a function of state only; it never depends combinationally on in_valid.

## Structure
- Shared package text_pkg holds:
  - ASCII constants CH_SPACE = 0x20, CH_BS = 0x08, CH_LF = 0x0A, CH_CR = 0x0D, CH_FF = 0x0C, CH_PRINT_LO = 0x20, CH_PRINT_HI = 0x7E.
  - The state enum {ST_CLEAR, ST_IDLE}.
  - Display geometry defaults (COLS = 16, ROWS = 2, char cell 8×16).
- One sub-module, text_ram: simple dual-port RAM, ROWS*COLS × 8, with one synchronous write port and one synchronous read port, read-before-write. The FSM, cursor logic and address arithmetic live in text_line_writer.

## Test plan
- Reset then release:
  - busy = 1 for exactly 32 cycles, then in_ready = 1 and cursor = (0,0).
  - Reads of all 32 cells return 0x20.
- Send "HI" back-to-back: cell (0,0) = 0x48, cell (0,1) = 0x49, cursor = (0,2); rd_char follows rd_col with 1-cycle latency.
- Send 16 × 'A', then 16 × 'B':
  - Cursor goes to (1,0) after the 16th byte and wraps to (0,0) after the 32nd.
  - Row 0 holds all 0x41 and row 1 all 0x42.
- Control codes:
  - "AB", then BS: cursor (0,1), cell (0,1) = 0x20.
  - BS at col 0: cursor stays (0,0), cell (0,0) = 0x20.
  - CR: col = 0. LF: row toggles, col unchanged.
  - Byte 0x07: accepted, no state change.
- FF after filling the buffer:
  - in_ready falls on the next cycle and busy is high for 32 cycles.
  - Every cell reads 0x20 afterwards and cursor = (0,0).
- Assert rst at clear cycle 10 for 3 cycles: after release, the clear restarts at address 0 and busy lasts a full 32 cycles.
